// File: rtl/arm_motion_seq.sv
// rtl/arm_motion_seq.sv - rate-limited two-joint motion sequencer feeding the arm PWM block
module arm_motion_seq #(
    parameter int unsigned STEP       = 1,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned SETTLE_CYC = 1000000,
    parameter int unsigned XITA_MAX   = 180,
    parameter int unsigned INIT_XITA1 = 90,
    parameter int unsigned INIT_XITA2 = 90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_xita1,
    input  logic [31:0] cmd_xita2,
    input  logic        stop,
    output logic [31:0] xita1,
    output logic [31:0] xita2,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] STEP_W      = 32'(STEP);
    localparam logic [31:0] TICK_LAST   = 32'(TICK_DIV - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] MAX_W       = 32'(XITA_MAX);
    localparam logic [31:0] INIT1_W     = 32'(INIT_XITA1);
    localparam logic [31:0] INIT2_W     = 32'(INIT_XITA2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] tgt1, tgt2, tgt1_d, tgt2_d;
    logic [31:0] xita1_d, xita2_d;
    logic [31:0] tick_cnt, tick_d;
    logic [31:0] settle_cnt, settle_d;
    logic        done_d;

    // Targets beyond the mechanical range are pulled back to XITA_MAX.
    function automatic logic [31:0] clamp(input logic [31:0] v);
        return (v > MAX_W) ? MAX_W : v;
    endfunction

    // One bounded step toward the target; the remaining distance caps the
    // step so the joint lands exactly on target and never wraps.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt);
        logic [31:0] diff;
        logic [31:0] res;
        res = cur;
        if (cur < tgt) begin
            diff = tgt - cur;
            res  = cur + ((diff < STEP_W) ? diff : STEP_W);
        end else if (cur > tgt) begin
            diff = cur - tgt;
            res  = cur - ((diff < STEP_W) ? diff : STEP_W);
        end
        return res;
    endfunction

    assign cmd_ready = (state == S_IDLE);

    // Next-state and datapath: accept, slew on ticks, settle, stop handling.
    always_comb begin
        state_d  = state;
        tgt1_d   = tgt1;
        tgt2_d   = tgt2;
        xita1_d  = xita1;
        xita2_d  = xita2;
        tick_d   = tick_cnt;
        settle_d = settle_cnt;
        done_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    tgt1_d  = clamp(cmd_xita1);
                    tgt2_d  = clamp(cmd_xita2);
                    tick_d  = 32'd0;
                    state_d = S_MOVE;
                end
            end
            S_MOVE: begin
                if (stop) begin
                    // Freeze: the present pose becomes the target, no step this edge.
                    tgt1_d   = xita1;
                    tgt2_d   = xita2;
                    settle_d = 32'd0;
                    state_d  = S_SETTLE;
                end else if ((xita1 == tgt1) && (xita2 == tgt2)) begin
                    settle_d = 32'd0;
                    state_d  = S_SETTLE;
                end else begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_d  = 32'd0;
                        xita1_d = step_toward(xita1, tgt1);
                        xita2_d = step_toward(xita2, tgt2);
                    end else begin
                        tick_d = tick_cnt + 32'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    // A stop during settling restarts the hold window.
                    tgt1_d   = xita1;
                    tgt2_d   = xita2;
                    settle_d = 32'd0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_cnt + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pose and counter registers; busy tracks the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            xita1      <= INIT1_W;
            xita2      <= INIT2_W;
            tgt1       <= INIT1_W;
            tgt2       <= INIT2_W;
            tick_cnt   <= 32'd0;
            settle_cnt <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            xita1      <= xita1_d;
            xita2      <= xita2_d;
            tgt1       <= tgt1_d;
            tgt2       <= tgt2_d;
            tick_cnt   <= tick_d;
            settle_cnt <= settle_d;
            busy       <= (state_d != S_IDLE);
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_arm_motion_seq.sv
// tb/tb_arm_motion_seq.sv - scoreboard bench for arm_motion_seq
module tb_arm_motion_seq;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_xita1;
    logic [31:0] cmd_xita2;
    logic        stop;
    logic [31:0] xita1;
    logic [31:0] xita2;
    logic        busy;
    logic        done;

    arm_motion_seq #(
        .STEP(1), .TICK_DIV(4), .SETTLE_CYC(8),
        .XITA_MAX(180), .INIT_XITA1(90), .INIT_XITA2(90)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_xita1(cmd_xita1), .cmd_xita2(cmd_xita2),
        .stop(stop),
        .xita1(xita1), .xita2(xita2),
        .busy(busy), .done(done)
    );

    typedef struct {
        int          cyc;
        logic [31:0] x1;
        logic [31:0] x2;
    } ev_t;

    ev_t mv_q[$];
    ev_t dn_q[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    logic [31:0] p1, p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_mv(input int c, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.cyc = c; e.x1 = a; e.x2 = b;
        mv_q.push_back(e);
    endfunction

    function automatic void push_dn(input int c, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.cyc = c; e.x1 = a; e.x2 = b;
        dn_q.push_back(e);
    endfunction

    // Monitor: every pose change and every done pulse must match the next expectation.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (xita1 !== p1 || xita2 !== p2) begin
                if (mv_q.size() == 0) begin
                    chk("unexpected_move_x1", {32'd0, xita1}, {32'd0, p1});
                    chk("unexpected_move_x2", {32'd0, xita2}, {32'd0, p2});
                end else begin
                    e = mv_q.pop_front();
                    chk("move_cycle", 64'(cyc), 64'(e.cyc));
                    chk("move_x1", {32'd0, xita1}, {32'd0, e.x1});
                    chk("move_x2", {32'd0, xita2}, {32'd0, e.x2});
                end
            end
            if (done === 1'b1) begin
                if (dn_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = dn_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_x1", {32'd0, xita1}, {32'd0, e.x1});
                    chk("done_x2", {32'd0, xita2}, {32'd0, e.x2});
                    chk("done_busy", 64'(busy), 64'd0);
                    chk("done_ready", 64'(cmd_ready), 64'd1);
                end
            end
        end
        p1 = xita1;
        p2 = xita2;
    end

    // Accept one command; returns the accept edge number.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int e0);
        cmd_xita1 = a;
        cmd_xita2 = b;
        cmd_valid = 1'b1;
        chk("ready_before_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (dn_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dn_q.size() != 0) begin
            bad++;
            $display("FAIL done_timeout: pending %0d expected 0", dn_q.size());
            dn_q.delete();
            mv_q.delete();
        end
        @(negedge clk);
    endtask

    // Synchronous reset pulse; pose returns to 90/90 at the reset edge.
    task automatic do_reset(input logic [31:0] cur1, input logic [31:0] cur2);
        rst = 1'b1;
        cmd_valid = 1'b0;
        if (cur1 != 32'd90 || cur2 != 32'd90) push_mv(cyc + 1, 32'd90, 32'd90);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_x1", {32'd0, xita1}, 64'd90);
        chk("rst_x2", {32'd0, xita2}, 64'd90);
    endtask

    initial begin
        int e0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_xita1 = 32'd0;
        cmd_xita2 = 32'd0;
        stop      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("init_x1", {32'd0, xita1}, 64'd90);
        chk("init_x2", {32'd0, xita2}, 64'd90);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_done", 64'(done), 64'd0);
        chk("init_ready", 64'(cmd_ready), 64'd1);
        mon_en = 1'b1;

        // 1: single joint, three ticks
        send(32'd93, 32'd90, e0);
        push_mv(e0 + 4, 32'd91, 32'd90);
        push_mv(e0 + 8, 32'd92, 32'd90);
        push_mv(e0 + 12, 32'd93, 32'd90);
        push_dn(e0 + 21, 32'd93, 32'd90);
        wait_done(500);
        chk("t1_busy_after", 64'(busy), 64'd0);
        do_reset(32'd93, 32'd90);

        // 2: opposite directions, joint 1 arrives first and holds
        send(32'd88, 32'd95, e0);
        push_mv(e0 + 4, 32'd89, 32'd91);
        push_mv(e0 + 8, 32'd88, 32'd92);
        push_mv(e0 + 12, 32'd88, 32'd93);
        push_mv(e0 + 16, 32'd88, 32'd94);
        push_mv(e0 + 20, 32'd88, 32'd95);
        push_dn(e0 + 29, 32'd88, 32'd95);
        wait_done(500);
        do_reset(32'd88, 32'd95);

        // 3: clamp to 180 and run joint 2 down to 0 without wrap
        send(32'd200, 32'd0, e0);
        for (int k = 1; k <= 90; k++) push_mv(e0 + 4 * k, 32'(90 + k), 32'(90 - k));
        push_dn(e0 + 369, 32'd180, 32'd0);
        wait_done(500);
        do_reset(32'd180, 32'd0);

        // 4: zero-length move
        send(32'd90, 32'd90, e0);
        push_dn(e0 + 9, 32'd90, 32'd90);
        wait_done(500);

        // 5: stop at E0+10 coincides with nothing; the tick at E0+12 must not step
        send(32'd100, 32'd90, e0);
        push_mv(e0 + 4, 32'd91, 32'd90);
        push_mv(e0 + 8, 32'd92, 32'd90);
        push_dn(e0 + 18, 32'd92, 32'd90);
        repeat (9) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(500);
        do_reset(32'd92, 32'd90);

        // 6a: command ignored during MOVE, then reset mid-move with no done
        send(32'd95, 32'd90, e0);
        push_mv(e0 + 4, 32'd91, 32'd90);
        repeat (3) @(negedge clk);
        cmd_xita1 = 32'd50;
        cmd_xita2 = 32'd50;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("move_ready_low", 64'(cmd_ready), 64'd0);
        end
        do_reset(32'd91, 32'd90);
        repeat (12) @(negedge clk);

        // 6b: a command held through MOVE/SETTLE is taken in the done cycle
        cmd_xita1 = 32'd91;
        cmd_xita2 = 32'd90;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        cmd_xita1 = 32'd90;
        cmd_xita2 = 32'd90;
        push_mv(e0 + 4, 32'd91, 32'd90);
        push_dn(e0 + 13, 32'd91, 32'd90);
        push_mv(e0 + 18, 32'd90, 32'd90);
        push_dn(e0 + 27, 32'd90, 32'd90);
        repeat (2) begin
            @(negedge clk);
            chk("held_ready_low", 64'(cmd_ready), 64'd0);
        end
        for (int n = 0; n < 40 && cyc < e0 + 14; n++) @(negedge clk);
        cmd_valid = 1'b0;
        chk("second_accept_busy", 64'(busy), 64'd1);
        wait_done(500);

        chk("move_queue_empty", 64'(mv_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
